// File: rtl/sound_event_scheduler.sv
// Fixed-priority scheduler that plays short frame-timed melodies for game sound events on one tone bus.
// Optional build macro SND_PREEMPT_EN: a pending win/lose aborts a coin/hit melody at the next frame.
module sound_event_scheduler #(
   parameter int NOTE_FRAMES = 4,
   parameter int GAP_FRAMES  = 1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       coin_req,
   input  logic       hit_req,
   input  logic       win_req,
   input  logic       lose_req,
   output logic [3:0] tone_code,
   output logic       tone_en,
   output logic [1:0] active_event,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t     state, next_state;
   logic [3:0] req, req_q, req_qq, rise, pending, clear;
   logic [1:0] grant_event, index;
   logic [3:0] count;
   logic       grant, note_end, gap_end, last_note, preempt;

   // Bit position doubles as the event code and as the priority rank.
   assign req  = {lose_req, win_req, hit_req, coin_req};
   assign rise = req_q & ~req_qq;

   function automatic logic [3:0] melody_note(input logic [1:0] ev, input logic [1:0] idx);
      case ({ev, idx})
         4'b00_00: melody_note = 4'd10;
         4'b00_01: melody_note = 4'd12;
         4'b01_00: melody_note = 4'd3;
         4'b10_00: melody_note = 4'd1;
         4'b10_01: melody_note = 4'd5;
         4'b10_10: melody_note = 4'd8;
         4'b10_11: melody_note = 4'd12;
         4'b11_00: melody_note = 4'd12;
         4'b11_01: melody_note = 4'd8;
         4'b11_10: melody_note = 4'd5;
         4'b11_11: melody_note = 4'd2;
         default:  melody_note = 4'd0;
      endcase
   endfunction

   function automatic logic [1:0] last_index(input logic [1:0] ev);
      case (ev)
         2'd0:    last_index = 2'd1;
         2'd1:    last_index = 2'd0;
         default: last_index = 2'd3;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant_event = 2'd0;
      if (pending[3])      grant_event = 2'd3;
      else if (pending[2]) grant_event = 2'd2;
      else if (pending[1]) grant_event = 2'd1;
   end

   assign note_end  = startOfFrame && (count == 4'(NOTE_FRAMES - 1));
   assign gap_end   = startOfFrame && (count == 4'(GAP_FRAMES - 1));
   assign last_note = (index == last_index(active_event));

`ifdef SND_PREEMPT_EN
   assign preempt = (state == PLAY) && startOfFrame && !active_event[1] && (pending[3] || pending[2]);
`else
   assign preempt = 1'b0;
`endif

   assign grant = ((state == IDLE) && (pending != 4'd0)) || preempt;
   assign clear = grant ? (4'd1 << grant_event) : 4'd0;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (pending != 4'd0) next_state = PLAY;
         PLAY: begin
            if (preempt) next_state = PLAY;
            else if (note_end && last_note) next_state = (GAP_FRAMES == 0) ? IDLE : GAP;
         end
         GAP:  if (gap_end) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      tone_code = 4'd0;
      tone_en   = 1'b0;
      busy      = (state != IDLE);
      if (state == PLAY) begin
         tone_code = melody_note(active_event, index);
         tone_en   = 1'b1;
      end
   end

   // Request edges, pending set, note/frame counters and the done pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         req_q        <= 4'd0;
         req_qq       <= 4'd0;
         pending      <= 4'd0;
         active_event <= 2'd0;
         index        <= 2'd0;
         count        <= 4'd0;
         done         <= 1'b0;
      end else begin
         req_q   <= req;
         req_qq  <= req_q;
         pending <= (pending & ~clear) | rise;
         done    <= 1'b0;
         if (grant) begin
            active_event <= grant_event;
            index        <= 2'd0;
            count        <= 4'd0;
         end else if (state == PLAY) begin
            if (note_end) begin
               count <= 4'd0;
               if (last_note) done  <= 1'b1;
               else           index <= index + 2'd1;
            end else if (startOfFrame) begin
               count <= count + 4'd1;
            end
         end else if (state == GAP) begin
            if (gap_end)           count <= 4'd0;
            else if (startOfFrame) count <= count + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Self-checking bench: table vectors, directed corner sequences, and random stimulus against a frame-level model.
// Two instances run in lockstep: (NOTE=4, GAP=1) and (NOTE=2, GAP=0).
module tb_sound_event_scheduler;

   logic clk = 1'b0;
   logic resetN, sof, coin_req, hit_req, win_req, lose_req;

   logic [3:0] tone_a, tone_b;
   logic       en_a, en_b, busy_a, busy_b, done_a, done_b;
   logic [1:0] ev_a, ev_b;

   always #5 clk = ~clk;

   sound_event_scheduler #(.NOTE_FRAMES(4), .GAP_FRAMES(1)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(sof),
      .coin_req(coin_req), .hit_req(hit_req), .win_req(win_req), .lose_req(lose_req),
      .tone_code(tone_a), .tone_en(en_a), .active_event(ev_a), .busy(busy_a), .done(done_a)
   );

   sound_event_scheduler #(.NOTE_FRAMES(2), .GAP_FRAMES(0)) dut0 (
      .clk(clk), .resetN(resetN), .startOfFrame(sof),
      .coin_req(coin_req), .hit_req(hit_req), .win_req(win_req), .lose_req(lose_req),
      .tone_code(tone_b), .tone_en(en_b), .active_event(ev_b), .busy(busy_b), .done(done_b)
   );

   // Model: mode 0 idle, 1 playing, 2 silent gap; 'left' counts frames remaining down to zero.
   typedef struct {
      logic [3:0] h1, h2, pend;
      int         mode, ev, idx, left;
      logic       done;
   } mdl_t;

   typedef struct {
      logic       coin;
      logic [8:0] exp;
   } vec_t;

   mdl_t       m_a, m_b;
   logic [3:0] mel [4][4];
   int         mel_len [4];
   int         n_checks = 0, n_pass = 0;
   logic [5:0] note_log [$];
   logic [5:0] last_logged;
   logic       last_en;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic int highest(input logic [3:0] p);
      for (int i = 3; i >= 0; i--) if (p[i]) return i;
      return -1;
   endfunction

   function automatic void model_reset(output mdl_t s);
      s.h1 = 0; s.h2 = 0; s.pend = 0;
      s.mode = 0; s.ev = 0; s.idx = 0; s.left = 0; s.done = 0;
   endfunction

   task automatic model_step(inout mdl_t s, input int nf, input int gf);
      logic [3:0] rise, clr;
      int         hp;
      logic       pre;
      rise = s.h1 & ~s.h2;
      clr = 0;
      s.done = 0;
      hp = highest(s.pend);
`ifdef SND_PREEMPT_EN
      pre = (s.mode == 1) && sof && (s.ev < 2) && (s.pend[3] || s.pend[2]);
`else
      pre = 1'b0;
`endif
      if (s.mode == 0) begin
         if (hp >= 0) begin
            s.ev = hp; clr[hp] = 1'b1; s.mode = 1; s.idx = 0; s.left = nf;
         end
      end else if (s.mode == 1) begin
         if (pre) begin
            s.ev = hp; clr[hp] = 1'b1; s.idx = 0; s.left = nf;
         end else if (sof) begin
            s.left--;
            if (s.left == 0) begin
               if (s.idx == mel_len[s.ev] - 1) begin
                  s.done = 1'b1;
                  s.mode = (gf == 0) ? 0 : 2;
                  s.left = gf;
               end else begin
                  s.idx++;
                  s.left = nf;
               end
            end
         end
      end else if (sof) begin
         s.left--;
         if (s.left == 0) s.mode = 0;
      end
      s.pend = (s.pend & ~clr) | rise;
      s.h2 = s.h1;
      s.h1 = {lose_req, win_req, hit_req, coin_req};
   endtask

   function automatic logic [8:0] model_out(input mdl_t s);
      logic [3:0] t;
      t = (s.mode == 1) ? mel[s.ev][s.idx] : 4'd0;
      return {t, s.mode == 1, 2'(s.ev), s.mode != 0, s.done};
   endfunction

   // One clock: advance both models with the inputs the DUTs see, then compare #1 after the edge.
   task automatic step();
      model_step(m_a, 4, 1);
      model_step(m_b, 2, 0);
      @(posedge clk);
      #1;
      check("model_a", {tone_a, en_a, ev_a, busy_a, done_a}, model_out(m_a));
      check("model_b", {tone_b, en_b, ev_b, busy_b, done_b}, model_out(m_b));
      if (en_a && (!last_en || {ev_a, tone_a} != last_logged)) note_log.push_back({ev_a, tone_a});
      last_logged = {ev_a, tone_a};
      last_en = en_a;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      coin_req = 0; hit_req = 0; win_req = 0; lose_req = 0;
      resetN = 1'b0;
      model_reset(m_a);
      model_reset(m_b);
      last_en = 1'b0;
      #1;
      check("reset_a", {tone_a, en_a, ev_a, busy_a, done_a}, 9'd0);
      check("reset_b", {tone_b, en_b, ev_b, busy_b, done_b}, 9'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetN = 1'b1;
   endtask

   task automatic check_log(input string name, input logic [5:0] exp [$]);
      check({name, "_len"}, note_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < note_log.size(); i++)
         check($sformatf("%s_note%0d", name, i), note_log[i], exp[i]);
   endtask

   initial begin
      vec_t       tbl [13];
      logic [5:0] exp_q [$];
      logic       found;

      mel = '{'{4'd10, 4'd12, 4'd0, 4'd0}, '{4'd3, 4'd0, 4'd0, 4'd0},
              '{4'd1, 4'd5, 4'd8, 4'd12}, '{4'd12, 4'd8, 4'd5, 4'd2}};
      mel_len = '{2, 1, 4, 4};
      sof = 1'b0;
      last_logged = 0;

      // Single coin edge, one frame per cycle: 10 x4, 12 x4, done with the gap frame, then idle.
      for (int i = 0; i < 13; i++) begin
         tbl[i].coin = (i == 0);
         tbl[i].exp  = 9'd0;
      end
      for (int i = 2; i <= 5; i++) tbl[i].exp = {4'd10, 1'b1, 2'd0, 1'b1, 1'b0};
      for (int i = 6; i <= 9; i++) tbl[i].exp = {4'd12, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[10].exp = {4'd0, 1'b0, 2'd0, 1'b1, 1'b1};

      do_reset();
      sof = 1'b1;
      for (int i = 0; i < 13; i++) begin
         coin_req = tbl[i].coin;
         step();
         check($sformatf("t1_vec%0d", i), {tone_a, en_a, ev_a, busy_a, done_a}, tbl[i].exp);
      end

      // Simultaneous coin and lose: lose first, then coin.
      do_reset();
      note_log.delete();
      coin_req = 1; lose_req = 1;
      step();
      coin_req = 0; lose_req = 0;
      steps(40);
      exp_q = '{{2'd3, 4'd12}, {2'd3, 4'd8}, {2'd3, 4'd5}, {2'd3, 4'd2}, {2'd0, 4'd10}, {2'd0, 4'd12}};
      check_log("t2", exp_q);

      // Three hit edges during win coalesce into one hit melody.
      do_reset();
      note_log.delete();
      win_req = 1;
      step();
      win_req = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         hit_req = 1; step();
         hit_req = 0; step();
      end
      steps(40);
      exp_q = '{{2'd2, 4'd1}, {2'd2, 4'd5}, {2'd2, 4'd8}, {2'd2, 4'd12}, {2'd1, 4'd3}};
      check_log("t3", exp_q);

      // Lose arrives during coin's first note.
      do_reset();
      note_log.delete();
      coin_req = 1; step();
      coin_req = 0; steps(2);
      lose_req = 1; step();
      lose_req = 0;
      steps(40);
`ifdef SND_PREEMPT_EN
      exp_q = '{{2'd0, 4'd10}, {2'd3, 4'd12}, {2'd3, 4'd8}, {2'd3, 4'd5}, {2'd3, 4'd2}};
`else
      exp_q = '{{2'd0, 4'd10}, {2'd0, 4'd12}, {2'd3, 4'd12}, {2'd3, 4'd8}, {2'd3, 4'd5}, {2'd3, 4'd2}};
`endif
      check_log("t4", exp_q);

      // Reset during win note 8 silences at once and forgets everything.
      do_reset();
      win_req = 1; step();
      win_req = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (tone_a == 4'd8) found = 1'b1;
      end
      check("t5_reach_note8", found, 1);
      do_reset();
      note_log.delete();
      steps(20);
      check("t5_silent_after_reset", note_log.size(), 0);

      // Zero gap: hit starts the cycle after coin's single idle cycle.
      do_reset();
      coin_req = 1; step();
      coin_req = 0; hit_req = 1; step();
      hit_req = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (done_b) found = 1'b1;
      end
      check("t6_done_seen", found, 1);
      check("t6_idle_cycle", {busy_b, tone_b, en_b}, 6'd0);
      step();
      check("t6_hit_starts", {tone_b, en_b, ev_b}, {4'd3, 1'b1, 2'd1});

      // Random requests and frame pulses with occasional resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) coin_req = ~coin_req;
         if ($urandom_range(15) == 0) hit_req  = ~hit_req;
         if ($urandom_range(23) == 0) win_req  = ~win_req;
         if ($urandom_range(23) == 0) lose_req = ~lose_req;
         sof = ($urandom_range(2) == 0);
         if ($urandom_range(499) == 0) do_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
